// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset, then redirect, then sequential advance.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic [ADDR_WIDTH-1:0] pc_plus_step
);

    localparam logic [ADDR_WIDTH-1:0] STEP_W = ADDR_WIDTH'(PC_STEP);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    assign pc_plus_step = pc_q + STEP_W;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (advance) begin
            pc_d = pc_plus_step;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Sequential fetch stage with req/ack memory port and valid/ready decode port.
// Optional FETCH_PERF_COUNTERS_EN adds saturating fetch/squash counters.
//
// state | meaning
// IDLE  | no request outstanding, waiting for fetch_enable
// REQ   | read outstanding at mem_addr, waiting for mem_ack
// HOLD  | instruction presented to decode, waiting for ir_ready
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fetch_enable,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [DATA_WIDTH-1:0] instruction_register,
    output logic [ADDR_WIDTH-1:0] instruction_pc,
    output logic [ADDR_WIDTH-1:0] incremented_program_counter,
    output logic                  ir_valid,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [15:0]           fetch_count,
    output logic [15:0]           squash_count,
`endif
    input  logic                  ir_ready
);

    fetch_state_e          state_q, state_d;
    logic                  squash_q, squash_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [ADDR_WIDTH-1:0] ir_pc_q;
    logic [ADDR_WIDTH-1:0] ir_pc_inc_q;

    logic                  deliver;
    logic                  discard;
    logic                  load_addr;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] pc_plus_step;

    fetch_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC),
        .PC_STEP    (PC_STEP)
    ) u_pc_reg (
        .clock           (clock),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .advance         (deliver),
        .pc              (pc),
        .pc_next         (pc_next),
        .pc_plus_step    (pc_plus_step)
    );

    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        deliver  = 1'b0;
        discard  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_enable) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (squash_q || redirect_valid) begin
                        discard  = 1'b1;
                        squash_d = 1'b0;
                        state_d  = fetch_enable ? ST_REQ : ST_IDLE;
                    end else begin
                        deliver = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Address must stay put until the ack; remember to drop the data.
                    squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    discard = 1'b1;
                    state_d = fetch_enable ? ST_REQ : ST_IDLE;
                end else if (ir_ready) begin
                    state_d = fetch_enable ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new address is latched on every entry into REQ, including REQ->REQ after an ack.
    assign load_addr = (state_d == ST_REQ) && !((state_q == ST_REQ) && !mem_ack);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            squash_q    <= 1'b0;
            mem_addr_q  <= RESET_PC;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_pc_inc_q <= '0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            if (load_addr) begin
                mem_addr_q <= pc_next;
            end
            if (deliver) begin
                ir_q        <= mem_rdata;
                ir_pc_q     <= pc;
                ir_pc_inc_q <= pc_plus_step;
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] squash_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (deliver && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (discard && (squash_cnt_q != '1)) begin
                squash_cnt_q <= squash_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign squash_count = squash_cnt_q;
`endif

    assign mem_req                     = (state_q == ST_REQ);
    assign mem_addr                    = mem_addr_q;
    assign ir_valid                    = (state_q == ST_HOLD);
    assign instruction_register        = ir_q;
    assign instruction_pc              = ir_pc_q;
    assign incremented_program_counter = ir_pc_inc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit; checks counters when FETCH_PERF_COUNTERS_EN is defined.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_enable;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic [15:0] instruction_register;
    logic [7:0]  instruction_pc;
    logic [7:0]  incremented_program_counter;
    logic        ir_valid;
    logic        ir_ready;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [15:0] fetch_count;
    logic [15:0] squash_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (8),
        .RESET_PC   (8'h00),
        .PC_STEP    (1)
    ) dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .fetch_enable                (fetch_enable),
        .mem_req                     (mem_req),
        .mem_addr                    (mem_addr),
        .mem_ack                     (mem_ack),
        .mem_rdata                   (mem_rdata),
        .redirect_valid              (redirect_valid),
        .redirect_target             (redirect_target),
        .instruction_register        (instruction_register),
        .instruction_pc              (instruction_pc),
        .incremented_program_counter (incremented_program_counter),
        .ir_valid                    (ir_valid),
`ifdef FETCH_PERF_COUNTERS_EN
        .fetch_count                 (fetch_count),
        .squash_count                (squash_count),
`endif
        .ir_ready                    (ir_ready)
    );

    always #5 clock = ~clock;

    // {instruction_register, instruction_pc, incremented_pc, ir_valid, mem_req}
    function automatic logic [33:0] snap();
        return {instruction_register, instruction_pc, incremented_program_counter, ir_valid, mem_req};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; fetch_enable = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        redirect_valid = 1'b0; redirect_target = '0; ir_ready = 1'b0;
        tick(); tick();
        n_cmp++;
        if (snap() !== 34'h0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected %h", snap(), 34'h0);
        end
        n_cmp++;
        if (mem_addr !== 8'h00) begin
            n_err++; $display("FAIL reset_addr: got %h expected 00", mem_addr);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++; $display("FAIL idle_no_req: got %b expected 0", mem_req);
        end
    endtask

    task automatic test_basic_fetch();
        fetch_enable = 1'b1;
        tick();
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin
            n_err++; $display("FAIL basic_req: got %b/%h expected 1/00", mem_req, mem_addr);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (snap() !== {16'hA5A5, 8'h00, 8'h01, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL basic_deliver: got %h expected %h", snap(), {16'hA5A5, 8'h00, 8'h01, 1'b1, 1'b0});
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (snap() !== {16'hA5A5, 8'h00, 8'h01, 1'b1, 1'b0}) begin
                n_err++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, snap(), {16'hA5A5, 8'h00, 8'h01, 1'b1, 1'b0});
            end
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        n_cmp++;
        if ({snap(), mem_addr} !== {16'hA5A5, 8'h00, 8'h01, 1'b0, 1'b1, 8'h01}) begin
            n_err++; $display("FAIL stall_next_req: got %h expected %h", {snap(), mem_addr}, {16'hA5A5, 8'h00, 8'h01, 1'b0, 1'b1, 8'h01});
        end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (snap() !== {16'h1234, 8'h01, 8'h02, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL second_deliver: got %h expected %h", snap(), {16'h1234, 8'h01, 8'h02, 1'b1, 1'b0});
        end
        ir_ready = 1'b1; fetch_enable = 1'b0;
        tick();
        ir_ready = 1'b0;
        n_cmp++;
        if (snap() !== {16'h1234, 8'h01, 8'h02, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL disable_to_idle: got %h expected %h", snap(), {16'h1234, 8'h01, 8'h02, 1'b0, 1'b0});
        end
    endtask

    task automatic test_wrap();
        fetch_enable = 1'b1; redirect_valid = 1'b1; redirect_target = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 8'hFF}) begin
            n_err++; $display("FAIL wrap_req: got %b/%h expected 1/ff", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (snap() !== {16'hBEEF, 8'hFF, 8'h00, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL wrap_deliver: got %h expected %h", snap(), {16'hBEEF, 8'hFF, 8'h00, 1'b1, 1'b0});
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin
            n_err++; $display("FAIL wrap_next_addr: got %b/%h expected 1/00", mem_req, mem_addr);
        end
    endtask

    task automatic test_redirect_req();
        redirect_valid = 1'b1; redirect_target = 8'h40;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({mem_req, mem_addr, ir_valid} !== {1'b1, 8'h00, 1'b0}) begin
                n_err++; $display("FAIL redir_req_hold[%0d]: got %b/%h/%b expected 1/00/0", i, mem_req, mem_addr, ir_valid);
            end
            if (i < 2) tick();
        end
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        n_cmp++;
        if ({snap(), mem_addr} !== {16'hBEEF, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h40}) begin
            n_err++; $display("FAIL redir_req_discard: got %h expected %h", {snap(), mem_addr}, {16'hBEEF, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h40});
        end
        mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (snap() !== {16'h7777, 8'h40, 8'h41, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL redir_req_target: got %h expected %h", snap(), {16'h7777, 8'h40, 8'h41, 1'b1, 1'b0});
        end
    endtask

    task automatic test_redirect_hold();
        redirect_valid = 1'b1; redirect_target = 8'h80; ir_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; ir_ready = 1'b0;
        n_cmp++;
        if ({snap(), mem_addr} !== {16'h7777, 8'h40, 8'h41, 1'b0, 1'b1, 8'h80}) begin
            n_err++; $display("FAIL redir_hold: got %h expected %h", {snap(), mem_addr}, {16'h7777, 8'h40, 8'h41, 1'b0, 1'b1, 8'h80});
        end
`ifdef FETCH_PERF_COUNTERS_EN
        n_cmp++;
        if ({fetch_count, squash_count} !== {16'd4, 16'd2}) begin
            n_err++; $display("FAIL perf_after_hold: got %0d/%0d expected 4/2", fetch_count, squash_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1; redirect_target = 8'h10; mem_ack = 1'b1; mem_rdata = 16'h5555;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if ({snap(), mem_addr} !== {16'h7777, 8'h40, 8'h41, 1'b0, 1'b1, 8'h10}) begin
            n_err++; $display("FAIL same_cycle_discard: got %h expected %h", {snap(), mem_addr}, {16'h7777, 8'h40, 8'h41, 1'b0, 1'b1, 8'h10});
        end
        mem_rdata = 16'h6666;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (snap() !== {16'h6666, 8'h10, 8'h11, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL same_cycle_next: got %h expected %h", snap(), {16'h6666, 8'h10, 8'h11, 1'b1, 1'b0});
        end
`ifdef FETCH_PERF_COUNTERS_EN
        n_cmp++;
        if ({fetch_count, squash_count} !== {16'd5, 16'd3}) begin
            n_err++; $display("FAIL perf_after_same_cycle: got %0d/%0d expected 5/3", fetch_count, squash_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 8'h11}) begin
            n_err++; $display("FAIL mid_pre_req: got %b/%h expected 1/11", mem_req, mem_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({snap(), mem_addr} !== 42'h0) begin
            n_err++; $display("FAIL mid_async_reset: got %h expected 0", {snap(), mem_addr});
        end
`ifdef FETCH_PERF_COUNTERS_EN
        n_cmp++;
        if ({fetch_count, squash_count} !== 32'h0) begin
            n_err++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", fetch_count, squash_count);
        end
`endif
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if ({snap(), mem_addr} !== {16'h0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00}) begin
            n_err++; $display("FAIL mid_ack_ignored: got %h expected %h", {snap(), mem_addr}, {16'h0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00});
        end
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (snap() !== {16'h9999, 8'h00, 8'h01, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL mid_refetch: got %h expected %h", snap(), {16'h9999, 8'h00, 8'h01, 1'b1, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_wrap();
        test_redirect_req();
        test_redirect_hold();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
